// File: rtl/chocorrol_secuenciador.sv
// ----------------------------------------------------------------------------
// chocorrol_secuenciador
//
// Instruction sequencer in front of the Chocorrol datapath. Incoming 20-bit
// instructions are buffered in a FIFO and issued one at a time. Each issued
// instruction is held on DP_INSTR for LATENCIA cycles, and then DP_RESULTADO
// is captured and offered on a valid/ready output channel. NOPs (MC=00) and
// illegal encodings are popped and dropped, so the datapath never sees them.
// Illegal encodings also raise a sticky ERROR_OP flag.
//
// Instruction layout: {MC[19:18], OP1[17:13], ALUC[12:10], OP2[9:5], MB[4:0]}
//
// Ports:
//   CLK            in   clock, rising edge
//   RST            in   synchronous active-high reset
//   IN_VALIDO      in   producer offers IN_INSTR
//   IN_LISTO       out  FIFO not full (push happens on IN_VALIDO & IN_LISTO)
//   IN_INSTR       in   20-bit instruction
//   DP_INSTR       out  instruction presented to the datapath
//   DP_EN          out  one-cycle issue strobe
//   DP_RESULTADO   in   datapath result
//   OUT_VALIDO     out  captured result available
//   OUT_LISTO      in   consumer accepts the result
//   OUT_RESULTADO  out  captured result
//   OUT_MC         out  MC field of the instruction that produced the result
//   CUENTA         out  FIFO occupancy
//   ERROR_OP       out  sticky: an illegal instruction was dropped
// ----------------------------------------------------------------------------
module chocorrol_secuenciador #(
    parameter int PROFUNDIDAD = 8,
    parameter int LATENCIA    = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           IN_VALIDO,
    output logic                           IN_LISTO,
    input  logic [19:0]                    IN_INSTR,
    output logic [19:0]                    DP_INSTR,
    output logic                           DP_EN,
    input  logic [31:0]                    DP_RESULTADO,
    output logic                           OUT_VALIDO,
    input  logic                           OUT_LISTO,
    output logic [31:0]                    OUT_RESULTADO,
    output logic [1:0]                     OUT_MC,
    output logic [$clog2(PROFUNDIDAD):0]   CUENTA,
    output logic                           ERROR_OP
);

    localparam int AW = $clog2(PROFUNDIDAD);
    localparam int CW = AW + 1;
    // Wait counter only needs to hold LATENCIA-1.
    localparam int LW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_EMITIR  = 2'b01,
        ST_ESPERA  = 2'b10,
        ST_ENTREGA = 2'b11
    } estado_t;

    // Legal: MC is 01 or 10, and ALUC is any code except 011 and 101.
    function automatic logic f_es_legal(input logic [1:0] mc, input logic [2:0] aluc);
        logic mc_ok;
        logic aluc_ok;
        mc_ok   = (mc == 2'b01) || (mc == 2'b10);
        aluc_ok = (aluc != 3'b011) && (aluc != 3'b101);
        return mc_ok && aluc_ok;
    endfunction

    // FIFO storage and bookkeeping
    logic [19:0]   r_mem [PROFUNDIDAD];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_cuenta;

    // Sequencer state and registered outputs
    estado_t       r_estado;
    logic [LW-1:0] r_espera;
    logic [19:0]   r_dp_instr;
    logic          r_dp_en;
    logic          r_out_valido;
    logic [31:0]   r_out_res;
    logic [1:0]    r_out_mc;
    logic          r_error;

    // Combinational helpers and next-state values
    logic          w_lleno;
    logic          w_push;
    logic          w_pop;
    logic [19:0]   w_cabeza;
    logic          w_es_nop;
    logic          w_es_legal;
    estado_t       w_estado_sig;
    logic [LW-1:0] w_espera_sig;
    logic [19:0]   w_dp_instr_sig;
    logic          w_dp_en_sig;
    logic          w_out_valido_sig;
    logic [31:0]   w_out_res_sig;
    logic [1:0]    w_out_mc_sig;
    logic          w_error_sig;

    assign w_lleno    = (r_cuenta == CW'(PROFUNDIDAD));
    assign w_push     = IN_VALIDO && !w_lleno;
    // The head is consumed (issued or dropped) whenever IDLE sees a non-empty FIFO.
    assign w_pop      = (r_estado == ST_IDLE) && (r_cuenta != {CW{1'b0}});
    assign w_cabeza   = r_mem[r_rd_ptr];
    assign w_es_nop   = (w_cabeza[19:18] == 2'b00);
    assign w_es_legal = f_es_legal(w_cabeza[19:18], w_cabeza[12:10]);

    assign IN_LISTO      = !w_lleno;
    assign DP_INSTR      = r_dp_instr;
    assign DP_EN         = r_dp_en;
    assign OUT_VALIDO    = r_out_valido;
    assign OUT_RESULTADO = r_out_res;
    assign OUT_MC        = r_out_mc;
    assign CUENTA        = r_cuenta;
    assign ERROR_OP      = r_error;

    // FIFO data write; storage needs no reset because occupancy gates every read.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= IN_INSTR;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_cuenta <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cuenta <= r_cuenta + CW'(1);
                2'b01:   r_cuenta <= r_cuenta - CW'(1);
                default: r_cuenta <= r_cuenta;
            endcase
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        w_estado_sig     = r_estado;
        w_espera_sig     = r_espera;
        w_dp_instr_sig   = r_dp_instr;
        w_dp_en_sig      = 1'b0;
        w_out_valido_sig = r_out_valido;
        w_out_res_sig    = r_out_res;
        w_out_mc_sig     = r_out_mc;
        w_error_sig      = r_error;
        case (r_estado)
            ST_IDLE: begin
                if (w_pop) begin
                    if (w_es_legal) begin
                        // DP_EN is registered, so it is high during EMITIR.
                        w_dp_instr_sig = w_cabeza;
                        w_dp_en_sig    = 1'b1;
                        w_estado_sig   = ST_EMITIR;
                    end else if (!w_es_nop) begin
                        w_error_sig = 1'b1;
                    end else begin
                        w_error_sig = r_error;
                    end
                end else begin
                    w_estado_sig = ST_IDLE;
                end
            end
            ST_EMITIR: begin
                w_espera_sig = LW'(LATENCIA - 1);
                w_estado_sig = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (r_espera == {LW{1'b0}}) begin
                    w_out_res_sig    = DP_RESULTADO;
                    w_out_mc_sig     = r_dp_instr[19:18];
                    w_out_valido_sig = 1'b1;
                    w_estado_sig     = ST_ENTREGA;
                end else begin
                    w_espera_sig = r_espera - LW'(1);
                end
            end
            ST_ENTREGA: begin
                if (OUT_LISTO) begin
                    w_out_valido_sig = 1'b0;
                    w_estado_sig     = ST_IDLE;
                end else begin
                    w_estado_sig = ST_ENTREGA;
                end
            end
            default: begin
                w_estado_sig = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight work.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_estado     <= ST_IDLE;
            r_espera     <= {LW{1'b0}};
            r_dp_instr   <= 20'd0;
            r_dp_en      <= 1'b0;
            r_out_valido <= 1'b0;
            r_out_res    <= 32'd0;
            r_out_mc     <= 2'b00;
            r_error      <= 1'b0;
        end else begin
            r_estado     <= w_estado_sig;
            r_espera     <= w_espera_sig;
            r_dp_instr   <= w_dp_instr_sig;
            r_dp_en      <= w_dp_en_sig;
            r_out_valido <= w_out_valido_sig;
            r_out_res    <= w_out_res_sig;
            r_out_mc     <= w_out_mc_sig;
            r_error      <= w_error_sig;
        end
    end

endmodule

// File: doc/chocorrol_secuenciador.md
Name: chocorrol_secuenciador

Overview:
Instruction sequencer in front of the Chocorrol datapath (20-bit instruction, 32-bit result). Buffers incoming instructions in a small FIFO and issues them one at a time, holding each stable for the datapath's fixed evaluation latency. Captures each result and hands it out on a valid/ready channel. Filters out NOPs and illegal encodings so the datapath never sees them.

Parameters:
PROFUNDIDAD, 8, FIFO depth in instructions (power of 2, ≥2)
LATENCIA, 2, cycles DP_INSTR is held in ESPERA before DP_RESULTADO is sampled (≥1)

Ports:
CLK  input  1  clock; all logic is on the rising edge
RST  input  1  synchronous, active-high reset
IN_VALIDO  input  1  producer has an instruction on IN_INSTR
IN_LISTO  output  1  FIFO can accept; asserted exactly when the FIFO is not full
IN_INSTR  input  20  {MC[19:18], OP1[17:13], ALUC[12:10], OP2[9:5], MB[4:0]}
DP_INSTR  output  20  instruction driven to the datapath
DP_EN  output  1  one-cycle issue strobe to the datapath
DP_RESULTADO  input  32  datapath result
OUT_VALIDO  output  1  result available
OUT_LISTO  input  1  consumer accepts the result
OUT_RESULTADO  output  32  captured result
OUT_MC  output  2  MC field of the instruction that produced OUT_RESULTADO
CUENTA  output  $clog2(PROFUNDIDAD)+1  FIFO occupancy
ERROR_OP  output  1  sticky flag: an illegal instruction was dropped

Behaviour:
- Reset: FIFO emptied, CUENTA=0, state IDLE, DP_INSTR=0, DP_EN=0, OUT_VALIDO=0, OUT_RESULTADO=0, OUT_MC=0, ERROR_OP=0. IN_LISTO=1 in the cycle after reset.
- Reset mid-operation: RST wins over everything else. The in-flight instruction and all queued instructions are discarded, and no result is delivered.
- FIFO push: on IN_VALIDO & IN_LISTO.
- FIFO pop: in IDLE when CUENTA>0.
- Simultaneous push and pop: CUENTA is unchanged and both take effect.
- Read and write pointers wrap modulo PROFUNDIDAD.
- No push occurs when full, because IN_LISTO=0.
- Legal instruction: MC ∈ {01, 10} and ALUC ∈ {000, 001, 010, 100, 110, 111}.
- MC=00 is a NOP: it is popped and dropped, with no DP_EN, no result, and no error.
- Any other encoding is illegal: it is popped and dropped, with no DP_EN and no result, and ERROR_OP is set to 1 until RST.
- State machine:
  - IDLE: if CUENTA>0, pop the head. If the head is legal, load it into DP_INSTR and go to EMITIR. If it is a NOP or illegal, stay in IDLE (one cycle is consumed per dropped entry).
  - EMITIR: DP_EN=1 for exactly this cycle. Load the wait counter with LATENCIA-1 and go to ESPERA.
  - ESPERA: DP_EN=0 and the counter decrements. When the counter is 0, sample DP_RESULTADO into OUT_RESULTADO and DP_INSTR[19:18] into OUT_MC, set OUT_VALIDO=1, and go to ENTREGA.
  - ENTREGA: OUT_VALIDO, OUT_RESULTADO and OUT_MC are held stable while OUT_LISTO=0. On OUT_LISTO=1, clear OUT_VALIDO and go to IDLE.
- DP_INSTR holds its value from EMITIR until the next legal issue; it is not cleared in IDLE.
- Latency: a legal instruction accepted at edge e0 into an empty FIFO with the block in IDLE is popped at e1. DP_EN is high between e1 and e2. OUT_VALIDO rises at edge e(2+LATENCIA), which is e4 for the default.
- Throughput: at most one result per LATENCIA+3 cycles when OUT_LISTO is held high.
- Ordering: results are delivered strictly in acceptance order, with dropped entries skipped.
- The FIFO keeps accepting instructions in every state, including during ENTREGA backpressure.

Test Plan:
Bench datapath model: register i holds value i, and DP_RESULTADO = ALU(OP1, OP2) combinationally.
- Single add: push 20'b01_00001_010_00010_00001, OUT_LISTO=1 → DP_EN pulses once. OUT_VALIDO rises 4 edges after acceptance with OUT_RESULTADO=3, OUT_MC=01.
- Burst in order: push AND(4,3), SUB(6,5), SLT(3,4), NOR(2,1) back-to-back with MC=10 → results 0, 1, 1, 32'hFFFFFFFC in that order, OUT_MC=10 each time, exactly 4 DP_EN pulses.
- Full/backpressure: OUT_LISTO=0, push 10 instructions → the first is issued, so 9 are accepted. IN_LISTO=0 while CUENTA=8. The 10th is held until OUT_LISTO=1. OUT_RESULTADO stays stable throughout the stall.
- Filtering: push MC=11 add, then MC=00, then 01_00010_010_00011_00001 → ERROR_OP=1 after the first pop and stays 1. Only one DP_EN pulse occurs, and the only result is 5.
- Illegal ALUC: push 10_00001_011_00001_00001 → dropped, ERROR_OP=1, no OUT_VALIDO.
- Reset mid-op: assert RST for 1 cycle in ESPERA with 3 instructions queued → the next cycle has CUENTA=0, OUT_VALIDO=0, ERROR_OP=0 and state IDLE. No stale result is ever delivered.
